// File: rtl/apa102_pkg.sv
// apa102_pkg: shared APA102 framing constants, scheduler state encoding, last_src codes and payload width helper
package apa102_pkg;
  localparam int START_BITS = 32;
  typedef enum logic [1:0] {IDLE, START, DATA, END} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B, SRC_REPLAY} src_t;
  function automatic int payload_width(input int num_leds);
    return 32 * num_leds;
  endfunction
endpackage

// File: rtl/apa102_bit_tx.sv
// apa102_bit_tx: one bit per 2*DIV clks (sck low then high), sda loaded at low-phase start; in: bit_valid/bit_data, out: bit_taken (bit latched), bit_done (high phase ending), sck_out/sda_out
module apa102_bit_tx #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_valid,
  input  logic bit_data,
  output logic bit_taken,
  output logic bit_done,
  output logic sck_out,
  output logic sda_out
);
  localparam int DW = $clog2(DIV) + 1;
  logic [DW-1:0] cnt;
  logic active, high, last;
  always_comb begin
    last = cnt == DW'(DIV - 1);
    bit_done = active && high && last;
    bit_taken = bit_valid && (!active || bit_done);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      active <= 1'b0;
      high <= 1'b0;
      cnt <= '0;
      sck_out <= 1'b0;
      sda_out <= 1'b0;
    end else if (bit_taken) begin
      active <= 1'b1;
      high <= 1'b0;
      cnt <= '0;
      sck_out <= 1'b0;
      sda_out <= bit_data;
    end else if (bit_done) begin
      active <= 1'b0;
      high <= 1'b0;
      cnt <= '0;
      sck_out <= 1'b0;
    end else if (active && last) begin
      high <= 1'b1;
      cnt <= '0;
      sck_out <= 1'b1;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/apa102_frame_sched.sv
// apa102_frame_sched: round-robin A/B frame arbiter with refresh replay, sends start/payload/end APA102 frame on sck_out/sda_out; status: busy, frame_done, last_src
module apa102_frame_sched import apa102_pkg::*; #(
  parameter int NUM_LEDS = 7,
  parameter int CLK_DIV = 4,
  parameter int END_BITS = 32,
  localparam int PW = payload_width(NUM_LEDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_a_valid,
  input  logic [PW-1:0] src_a_data,
  output logic          src_a_ready,
  input  logic          src_b_valid,
  input  logic [PW-1:0] src_b_data,
  output logic          src_b_ready,
  input  logic          refresh_tick,
  output logic          sck_out,
  output logic          sda_out,
  output logic          busy,
  output logic          frame_done,
  output logic [1:0]    last_src
);
  localparam int MX = PW > END_BITS ? PW : END_BITS;
  localparam int CW = $clog2((MX > START_BITS ? MX : START_BITS) + 1);
  localparam int IW = $clog2(PW);
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] frame_buf;
  logic [IW-1:0] idx;
  logic ptr, grant_a, grant_b, last_bit, bit_valid, bit_data, bit_taken, bit_done;
  // ptr=0 favours A on a tie; END holds cnt at END_BITS while the last bit finishes
  always_comb begin
    grant_a = src_a_valid && (!src_b_valid || !ptr);
    grant_b = src_b_valid && !grant_a;
    idx = IW'(PW - 1) - IW'(cnt);
    last_bit = state == START ? cnt == CW'(START_BITS - 1) : cnt == CW'(PW - 1);
    bit_valid = state != IDLE && !(state == END && cnt == CW'(END_BITS));
    bit_data = state == DATA ? frame_buf[idx] : state == END;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      frame_buf <= '0;
      ptr <= 1'b0;
      last_src <= SRC_NONE;
      src_a_ready <= 1'b0;
      src_b_ready <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      src_a_ready <= 1'b0;
      src_b_ready <= 1'b0;
      frame_done <= 1'b0;
      busy <= state != IDLE;
      case (state)
        IDLE:
          if (grant_a || grant_b) begin
            src_a_ready <= grant_a;
            src_b_ready <= grant_b;
            frame_buf <= grant_a ? src_a_data : src_b_data;
            last_src <= grant_a ? SRC_A : SRC_B;
            ptr <= grant_a;
            state <= START;
            cnt <= '0;
          end else if (refresh_tick) begin
            last_src <= SRC_REPLAY;
            state <= START;
            cnt <= '0;
          end
        START, DATA:
          if (bit_taken) begin
            cnt <= last_bit ? '0 : cnt + 1'b1;
            if (last_bit) state <= state == START ? DATA : END;
          end
        END:
          if (bit_done && !bit_valid) begin
            state <= IDLE;
            busy <= 1'b0;
            frame_done <= 1'b1;
          end else if (bit_taken) begin
            cnt <= cnt + 1'b1;
          end
      endcase
    end
  apa102_bit_tx #(.DIV(CLK_DIV)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .bit_valid(bit_valid),
    .bit_data(bit_data),
    .bit_taken(bit_taken),
    .bit_done(bit_done),
    .sck_out(sck_out),
    .sda_out(sda_out)
  );
endmodule
